// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Sequencing controller for the 5-stage pipeline. Produces
//               per-stage latch enables, bubble inserts and the FD flush
//               from the load-use hazard, branch redirect and the multdiv
//               handshake. Owns the multi-cycle multdiv stall, including a
//               hung-unit timeout and a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             haz,
    input  logic             dx_is_md,
    input  logic             branch_taken,
    input  logic             md_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             dx_bubble,
    output logic             xm_bubble,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int              c_TO_W    = $clog2(MD_TIMEOUT);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(MD_TIMEOUT - 1);

    localparam logic [1:0] c_ST_RUN     = 2'd0;
    localparam logic [1:0] c_ST_MD_WAIT = 2'd1;
    localparam logic [1:0] c_ST_MD_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [c_TO_W-1:0] r_toCnt;
    logic              r_mdTimeout;
    logic [CNT_W-1:0]  r_stallCnt;

    logic w_pcEn, w_fdEn, w_dxEn, w_xmEn, w_mwEn;
    logic w_fdFlush, w_dxBubble, w_xmBubble, w_mdStart;

    // Stage controls decoded from the current state and this cycle's inputs
    always_comb begin
        w_pcEn     = 1'b0;
        w_fdEn     = 1'b0;
        w_dxEn     = 1'b0;
        w_xmEn     = 1'b0;
        w_mwEn     = 1'b0;
        w_fdFlush  = 1'b0;
        w_dxBubble = 1'b0;
        w_xmBubble = 1'b0;
        w_mdStart  = 1'b0;
        if (!reset) begin
            case (r_state)
                c_ST_RUN: begin
                    w_xmEn = 1'b1;
                    w_mwEn = 1'b1;
                    if (branch_taken) begin
                        // Redirect wins: squash FD and DX, no stall
                        w_pcEn     = 1'b1;
                        w_fdEn     = 1'b1;
                        w_dxEn     = 1'b1;
                        w_fdFlush  = 1'b1;
                        w_dxBubble = 1'b1;
                    end else if (dx_is_md) begin
                        // Launch multdiv; md instruction holds in DX
                        w_mdStart  = 1'b1;
                        w_xmBubble = 1'b1;
                    end else if (haz) begin
                        w_dxEn     = 1'b1;
                        w_dxBubble = 1'b1;
                    end else begin
                        w_pcEn = 1'b1;
                        w_fdEn = 1'b1;
                        w_dxEn = 1'b1;
                    end
                end
                c_ST_MD_WAIT: begin
                    // Front frozen while older instructions drain
                    w_xmEn     = 1'b1;
                    w_mwEn     = 1'b1;
                    w_xmBubble = 1'b1;
                end
                c_ST_MD_DONE: begin
                    // md result moves to XM; a load-use hazard still stalls FD
                    w_pcEn     = !haz;
                    w_fdEn     = !haz;
                    w_dxEn     = 1'b1;
                    w_xmEn     = 1'b1;
                    w_mwEn     = 1'b1;
                    w_dxBubble = haz;
                end
                default: begin
                    w_pcEn = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state, multdiv timeout watchdog and stall-cycle counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_RUN;
            r_toCnt     <= '0;
            r_mdTimeout <= 1'b0;
            r_stallCnt  <= '0;
        end else begin
            if (!w_pcEn && (r_stallCnt != {CNT_W{1'b1}})) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
            case (r_state)
                c_ST_RUN: begin
                    if (!branch_taken && dx_is_md) begin
                        r_state <= c_ST_MD_WAIT;
                        r_toCnt <= '0;
                    end
                end
                c_ST_MD_WAIT: begin
                    if (md_ready) begin
                        r_state <= c_ST_MD_DONE;
                    end else if (r_toCnt == c_TO_LAST) begin
                        r_mdTimeout <= 1'b1;
                        r_state     <= c_ST_MD_DONE;
                    end else begin
                        r_toCnt <= r_toCnt + c_TO_W'(1);
                    end
                end
                c_ST_MD_DONE: begin
                    r_state <= c_ST_RUN;
                end
                default: begin
                    r_state <= c_ST_RUN;
                end
            endcase
        end
    end

    assign pc_en      = w_pcEn;
    assign fd_en      = w_fdEn;
    assign dx_en      = w_dxEn;
    assign xm_en      = w_xmEn;
    assign mw_en      = w_mwEn;
    assign fd_flush   = w_fdFlush;
    assign dx_bubble  = w_dxBubble;
    assign xm_bubble  = w_xmBubble;
    assign md_start   = w_mdStart;
    assign md_busy    = (r_state == c_ST_MD_WAIT) || (r_state == c_ST_MD_DONE);
    assign md_timeout = r_mdTimeout;
    assign stall_cnt  = r_stallCnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stall_ctrl
// Description : Self-checking bench for pipe_stall_ctrl. A reference model
//               tracks the multdiv operation by its age in cycles since
//               launch and predicts every output; scenario tasks add
//               directed checks on top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    localparam int MD_TO  = 8;
    localparam int CNT_W  = 6;
    localparam int C_MAXC = 63;

    logic clk;
    logic reset, haz, dx_is_md, branch_taken, md_ready;
    logic pc_en, fd_en, dx_en, xm_en, mw_en;
    logic fd_flush, dx_bubble, xm_bubble, md_start, md_busy, md_timeout;
    logic [CNT_W-1:0] stall_cnt;

    int nChecks = 0;
    int nFails  = 0;

    pipe_stall_ctrl #(.MD_TIMEOUT(MD_TO), .CNT_W(CNT_W)) dut (
        .clock(clk), .reset(reset), .haz(haz), .dx_is_md(dx_is_md),
        .branch_taken(branch_taken), .md_ready(md_ready),
        .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .dx_bubble(dx_bubble), .xm_bubble(xm_bubble),
        .md_start(md_start), .md_busy(md_busy), .md_timeout(md_timeout),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc, fd, dx, xm, mw, flush, dxBubble, xmBubble, start, busy}
    logic [9:0] obs;
    assign obs = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_bubble, xm_bubble, md_start, md_busy};

    // ---------------- reference model ----------------
    logic mBusy = 1'b0;      // multdiv in flight, result not yet accepted
    logic mDone = 1'b0;      // the single completion cycle
    int   mAge  = 0;         // cycles since md_start, valid while mBusy
    logic mTimedOut = 1'b0;
    int   mStalls = 0;

    function automatic logic [9:0] modelOuts(input logic rs, h, d, b, busy, done);
        logic [9:0] v;
        if (rs)        v = {9'b0, busy | done};
        else if (done) v = {!h, !h, 3'b111, 1'b0, h, 1'b0, 1'b0, 1'b1};
        else if (busy) v = 10'b0001100101;
        else if (b)    v = 10'b1111111000;
        else if (d)    v = 10'b0001100110;
        else if (h)    v = 10'b0011101000;
        else           v = 10'b1111100000;
        return v;
    endfunction

    logic [9:0] expVec;
    assign expVec = modelOuts(reset, haz, dx_is_md, branch_taken, mBusy, mDone);

    always @(posedge clk) begin
        if (reset) begin
            mBusy <= 1'b0; mDone <= 1'b0; mAge <= 0; mTimedOut <= 1'b0; mStalls <= 0;
        end else begin
            if (!expVec[9] && mStalls < C_MAXC) mStalls <= mStalls + 1;
            if (mDone) begin
                mDone <= 1'b0;
            end else if (mBusy) begin
                if (md_ready) begin
                    mBusy <= 1'b0; mDone <= 1'b1;
                end else if (mAge == MD_TO) begin
                    mBusy <= 1'b0; mDone <= 1'b1; mTimedOut <= 1'b1;
                end else begin
                    mAge <= mAge + 1;
                end
            end else if (!branch_taken && dx_is_md) begin
                mBusy <= 1'b1; mAge <= 1;
            end
        end
    end

    // Apply one cycle of inputs at the falling edge and settle
    task automatic tick(input logic h, d, b, r, rs);
        @(negedge clk);
        haz = h; dx_is_md = d; branch_taken = b; md_ready = r; reset = rs;
        #1;
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        nChecks++;
        if (obs[9:1] !== 9'b0) begin nFails++; $display("FAIL reset_outs got %b exp 000000000", obs[9:1]); end
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0, 0);
            nChecks++;
            if (obs !== 10'b1111100000) begin nFails++; $display("FAIL idle_outs cyc %0d got %b exp 1111100000", i, obs); end
            nChecks++;
            if (stall_cnt !== 6'd0 || md_timeout !== 1'b0) begin
                nFails++; $display("FAIL idle_regs cyc %0d stall %0d timeout %b exp 0 0", i, stall_cnt, md_timeout);
            end
        end
    endtask

    task automatic test_haz();
        tick(1, 0, 0, 0, 0);
        nChecks++;
        if (obs !== 10'b0011101000) begin nFails++; $display("FAIL haz_outs got %b exp 0011101000", obs); end
        tick(0, 0, 0, 0, 0);
        nChecks++;
        if (stall_cnt !== 6'd1) begin nFails++; $display("FAIL haz_stall got %0d exp 1", stall_cnt); end
        nChecks++;
        if (obs !== expVec) begin nFails++; $display("FAIL haz_after got %b exp %b", obs, expVec); end
    endtask

    task automatic test_md();
        int starts = 0, xmbs = 0, base;
        base = mStalls;
        for (int i = 0; i < 7; i++) begin
            tick(0, (i <= 4), 0, (i == 3), 0);
            starts += int'(md_start);
            xmbs   += int'(xm_bubble);
            nChecks++;
            if (obs !== expVec) begin nFails++; $display("FAIL md_outs cyc %0d got %b exp %b", i, obs, expVec); end
            nChecks++;
            if (md_busy !== (i >= 1 && i <= 4)) begin nFails++; $display("FAIL md_busy cyc %0d got %b exp %b", i, md_busy, (i >= 1 && i <= 4)); end
        end
        nChecks++;
        if (starts != 1) begin nFails++; $display("FAIL md_start_count got %0d exp 1", starts); end
        nChecks++;
        if (xmbs != 4) begin nFails++; $display("FAIL md_xm_bubbles got %0d exp 4", xmbs); end
        nChecks++;
        if (stall_cnt !== 6'(base + 4)) begin nFails++; $display("FAIL md_stall got %0d exp %0d", stall_cnt, base + 4); end
    endtask

    task automatic test_branch();
        int base;
        base = mStalls;
        tick(1, 1, 1, 0, 0);
        nChecks++;
        if (fd_flush !== 1'b1 || dx_bubble !== 1'b1 || md_start !== 1'b0 || pc_en !== 1'b1) begin
            nFails++; $display("FAIL branch_prio flush %b dxb %b start %b pc %b exp 1 1 0 1", fd_flush, dx_bubble, md_start, pc_en);
        end
        tick(0, 0, 0, 0, 0);
        nChecks++;
        if (md_busy !== 1'b0 || stall_cnt !== 6'(base)) begin
            nFails++; $display("FAIL branch_after busy %b stall %0d exp 0 %0d", md_busy, stall_cnt, base);
        end
    endtask

    task automatic test_timeout();
        int doneCyc = -1;
        tick(0, 1, 0, 0, 0);
        for (int c = 1; c <= 20 && doneCyc < 0; c++) begin
            tick(0, 1, 0, 0, 0);
            nChecks++;
            if (obs !== expVec) begin nFails++; $display("FAIL to_outs cyc %0d got %b exp %b", c, obs, expVec); end
            if (md_busy && !xm_bubble) doneCyc = c;
            else begin
                nChecks++;
                if (md_timeout !== 1'b0) begin nFails++; $display("FAIL to_early cyc %0d got 1 exp 0", c); end
            end
        end
        nChecks++;
        if (doneCyc != MD_TO + 1) begin nFails++; $display("FAIL to_done_cycle got %0d exp %0d", doneCyc, MD_TO + 1); end
        nChecks++;
        if (md_timeout !== 1'b1) begin nFails++; $display("FAIL to_flag got %b exp 1", md_timeout); end
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
        nChecks++;
        if (md_timeout !== 1'b1) begin nFails++; $display("FAIL to_sticky got %b exp 1", md_timeout); end
    endtask

    task automatic test_reset_mid();
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 1);
        nChecks++;
        if (obs[9:1] !== 9'b0) begin nFails++; $display("FAIL rstmid_outs got %b exp 000000000", obs[9:1]); end
        tick(0, 1, 0, 0, 0);
        nChecks++;
        if (md_start !== 1'b1 || md_busy !== 1'b0) begin nFails++; $display("FAIL rstmid_start start %b busy %b exp 1 0", md_start, md_busy); end
        nChecks++;
        if (stall_cnt !== 6'd0 || md_timeout !== 1'b0) begin
            nFails++; $display("FAIL rstmid_regs stall %0d timeout %b exp 0 0", stall_cnt, md_timeout);
        end
        tick(0, 1, 0, 1, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        nChecks++;
        if (obs !== 10'b1111100000) begin nFails++; $display("FAIL rstmid_resume got %b exp 1111100000", obs); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 70; i++) tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        nChecks++;
        if (stall_cnt !== 6'd63) begin nFails++; $display("FAIL sat_stall got %0d exp 63", stall_cnt); end
        nChecks++;
        if (obs !== 10'b1111100000) begin nFails++; $display("FAIL sat_outs got %b exp 1111100000", obs); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 80) == 0);
            nChecks++;
            if (obs !== expVec) begin nFails++; $display("FAIL rnd_outs cyc %0d got %b exp %b", i, obs, expVec); end
            nChecks++;
            if (stall_cnt !== 6'(mStalls) || md_timeout !== mTimedOut) begin
                nFails++; $display("FAIL rnd_regs cyc %0d stall %0d timeout %b exp %0d %b", i, stall_cnt, md_timeout, mStalls, mTimedOut);
            end
        end
    endtask

    initial begin
        reset = 1'b1; haz = 1'b0; dx_is_md = 1'b0; branch_taken = 1'b0; md_ready = 1'b0;
        test_reset();
        test_haz();
        test_md();
        test_branch();
        test_timeout();
        test_reset_mid();
        test_saturation();
        tick(0, 0, 0, 0, 1);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
